// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge
// Description : Core load/store port to Avalon-MM master bridge with lane
//               alignment, load extension, alignment checks and stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    input  logic        waitrequest_i,
    output logic [31:0] writedata_o,
    output logic [3:0]  byteenable_o,
    input  logic [31:0] readdata_i
);

    localparam int            c_cnt_w     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_limit = c_cnt_w'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
    localparam logic [1:0]    c_size_byte = 2'b00;
    localparam logic [1:0]    c_size_half = 2'b01;
    localparam logic [1:0]    c_size_word = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_size;
    logic                 r_sign;
    logic [1:0]           r_off;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_wait_cnt;

    logic                 w_legal;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata_al;
    logic [31:0]          w_rshift;
    logic [31:0]          w_load;
    logic                 w_timeout;

    always_comb begin
        w_legal    = 1'b0;
        w_be       = 4'b1111;
        w_wdata_al = wdata_i;
        case (size_i)
            c_size_byte: begin
                w_legal    = 1'b1;
                w_be       = 4'b0001 << addr_i[1:0];
                w_wdata_al = {24'd0, wdata_i[7:0]} << {addr_i[1:0], 3'b000};
            end
            c_size_half: begin
                w_legal    = ~addr_i[0];
                w_be       = 4'b0011 << addr_i[1:0];
                w_wdata_al = {16'd0, wdata_i[15:0]} << {addr_i[1:0], 3'b000};
            end
            c_size_word: begin
                w_legal    = (addr_i[1:0] == 2'b00);
            end
            default: begin
                w_legal    = 1'b0;
            end
        endcase
    end

    // Legal words always have offset 0, so the shifted bus doubles as the word result.
    assign w_rshift = readdata_i >> {r_off, 3'b000};

    always_comb begin
        w_load = w_rshift;
        case (r_size)
            c_size_byte: w_load = {{24{r_sign & w_rshift[7]}},  w_rshift[7:0]};
            c_size_half: w_load = {{16{r_sign & w_rshift[15]}}, w_rshift[15:0]};
            default:     w_load = w_rshift;
        endcase
    end

    assign w_timeout = (MAX_WAIT != 0) && waitrequest_i && (r_wait_cnt == c_cnt_limit);

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (!w_legal) begin
                        w_state_next = RESP;
                    end else if (we_i) begin
                        w_state_next = WRITE;
                    end else begin
                        w_state_next = READ;
                    end
                end
            end
            READ, WRITE: begin
                if (!waitrequest_i || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            address_o    <= 32'd0;
            byteenable_o <= 4'd0;
            writedata_o  <= 32'd0;
            read_o       <= 1'b0;
            write_o      <= 1'b0;
            rdata_o      <= 32'd0;
            r_size       <= 2'd0;
            r_sign       <= 1'b0;
            r_off        <= 2'd0;
            r_err        <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        if (w_legal) begin
                            address_o    <= {addr_i[31:2], 2'b00};
                            byteenable_o <= w_be;
                            writedata_o  <= we_i ? w_wdata_al : 32'd0;
                            read_o       <= ~we_i;
                            write_o      <= we_i;
                            r_size       <= size_i;
                            r_sign       <= sign_i;
                            r_off        <= addr_i[1:0];
                            r_err        <= 1'b0;
                            r_wait_cnt   <= '0;
                        end else begin
                            r_err        <= 1'b1;
                            rdata_o      <= 32'd0;
                        end
                    end
                end
                READ, WRITE: begin
                    if (!waitrequest_i) begin
                        read_o  <= 1'b0;
                        write_o <= 1'b0;
                        r_err   <= 1'b0;
                        if (r_state == READ) begin
                            rdata_o <= w_load;
                        end
                    end else if (w_timeout) begin
                        read_o  <= 1'b0;
                        write_o <= 1'b0;
                        r_err   <= 1'b1;
                        rdata_o <= 32'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = (r_state == RESP);
    assign err_o  = (r_state == RESP) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bridge
// Description : Directed self-checking bench for mem_bridge (MAX_WAIT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bridge;

    logic        clk;
    logic        reset_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sign_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic        waitrequest_i;
    logic [31:0] writedata_o;
    logic [3:0]  byteenable_o;
    logic [31:0] readdata_i;

    int errors = 0;
    int checks = 0;

    mem_bridge #(.MAX_WAIT(4)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .size_i        (size_i),
        .sign_i        (sign_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .address_o     (address_o),
        .read_o        (read_o),
        .write_o       (write_o),
        .waitrequest_i (waitrequest_i),
        .writedata_o   (writedata_o),
        .byteenable_o  (byteenable_o),
        .readdata_i    (readdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge; returns at the negedge after acceptance.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_i   = 1'b1;
        we_i    = we;
        size_i  = sz;
        sign_i  = sg;
        addr_i  = a;
        wdata_i = wd;
        @(negedge clk);
        req_i   = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b0;
        req_i         = 1'b0;
        we_i          = 1'b0;
        size_i        = 2'b00;
        sign_i        = 1'b0;
        addr_i        = 32'd0;
        wdata_i       = 32'd0;
        waitrequest_i = 1'b0;
        readdata_i    = 32'd0;
        #1;
        chk("rst_busy",  {31'd0, busy_o},  32'd0);
        chk("rst_done",  {31'd0, done_o},  32'd0);
        chk("rst_err",   {31'd0, err_o},   32'd0);
        chk("rst_read",  {31'd0, read_o},  32'd0);
        chk("rst_write", {31'd0, write_o}, 32'd0);
        chk("rst_be",    {28'd0, byteenable_o}, 32'd0);
        chk("rst_addr",  address_o,   32'd0);
        chk("rst_wdata", writedata_o, 32'd0);
        chk("rst_rdata", rdata_o,     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;

        // Word load, no stall
        readdata_i = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
        chk("wl_read",  {31'd0, read_o}, 32'd1);
        chk("wl_addr",  address_o, 32'h0000_0100);
        chk("wl_be",    {28'd0, byteenable_o}, 32'hF);
        chk("wl_busy",  {31'd0, busy_o}, 32'd1);
        chk("wl_done0", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        chk("wl_done",  {31'd0, done_o}, 32'd1);
        chk("wl_err",   {31'd0, err_o},  32'd0);
        chk("wl_rdata", rdata_o, 32'hDEADBEEF);
        chk("wl_read0", {31'd0, read_o}, 32'd0);
        @(negedge clk);
        chk("wl_idle",  {31'd0, busy_o}, 32'd0);
        chk("wl_done1", {31'd0, done_o}, 32'd0);

        // Signed and unsigned byte loads from lane 3
        readdata_i = 32'h80112233;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0);
        chk("sb_be",    {28'd0, byteenable_o}, 32'h8);
        chk("sb_addr",  address_o, 32'h0000_0100);
        @(negedge clk);
        chk("sb_done",  {31'd0, done_o}, 32'd1);
        chk("sb_rdata", rdata_o, 32'hFFFFFF80);
        @(negedge clk);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0);
        @(negedge clk);
        chk("ub_rdata", rdata_o, 32'h00000080);
        @(negedge clk);

        // Half store with three stall cycles; a request while busy must be dropped
        waitrequest_i = 1'b1;
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000ABCD);
        chk("hs_write1", {31'd0, write_o}, 32'd1);
        chk("hs_read",   {31'd0, read_o},  32'd0);
        chk("hs_be",     {28'd0, byteenable_o}, 32'hC);
        chk("hs_wdata",  writedata_o, 32'hABCD0000);
        chk("hs_addr",   address_o, 32'h0000_0200);
        @(negedge clk);
        chk("hs_write2", {31'd0, write_o}, 32'd1);
        chk("hs_done2",  {31'd0, done_o},  32'd0);
        req_i  = 1'b1;
        we_i   = 1'b0;
        size_i = 2'b10;
        addr_i = 32'h0000_0400;
        @(negedge clk);
        req_i  = 1'b0;
        chk("hs_write3", {31'd0, write_o}, 32'd1);
        chk("hs_ignore", address_o, 32'h0000_0200);
        @(negedge clk);
        chk("hs_write4", {31'd0, write_o}, 32'd1);
        chk("hs_done4",  {31'd0, done_o},  32'd0);
        chk("hs_wdata4", writedata_o, 32'hABCD0000);
        waitrequest_i = 1'b0;
        @(negedge clk);
        chk("hs_done",   {31'd0, done_o},  32'd1);
        chk("hs_err",    {31'd0, err_o},   32'd0);
        chk("hs_write0", {31'd0, write_o}, 32'd0);
        chk("hs_rdata",  rdata_o, 32'h00000080);
        @(negedge clk);
        chk("hs_idle",   {31'd0, busy_o}, 32'd0);
        chk("hs_done1",  {31'd0, done_o}, 32'd0);

        // Misaligned word load
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0);
        chk("mis_read",  {31'd0, read_o}, 32'd0);
        chk("mis_done",  {31'd0, done_o}, 32'd1);
        chk("mis_err",   {31'd0, err_o},  32'd1);
        chk("mis_rdata", rdata_o, 32'd0);
        @(negedge clk);
        chk("mis_idle",  {31'd0, busy_o}, 32'd0);
        chk("mis_err0",  {31'd0, err_o},  32'd0);

        // Reload a value, then time out with waitrequest stuck high
        readdata_i = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
        @(negedge clk);
        chk("rl_rdata", rdata_o, 32'hDEADBEEF);
        @(negedge clk);
        waitrequest_i = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_read%0d", i), {31'd0, read_o}, 32'd1);
            chk($sformatf("to_done%0d", i), {31'd0, done_o}, 32'd0);
            @(negedge clk);
        end
        chk("to_read0", {31'd0, read_o}, 32'd0);
        chk("to_done",  {31'd0, done_o}, 32'd1);
        chk("to_err",   {31'd0, err_o},  32'd1);
        chk("to_rdata", rdata_o, 32'd0);
        @(negedge clk);
        chk("to_idle",  {31'd0, busy_o}, 32'd0);

        // Asynchronous reset in the middle of a stalled read
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'd0);
        chk("ar_read1", {31'd0, read_o}, 32'd1);
        #2 reset_i = 1'b0;
        #1;
        chk("ar_read0", {31'd0, read_o}, 32'd0);
        chk("ar_busy",  {31'd0, busy_o}, 32'd0);
        chk("ar_addr",  address_o, 32'd0);
        chk("ar_be",    {28'd0, byteenable_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        chk("ar_nodone", {31'd0, done_o}, 32'd0);
        chk("ar_nobusy", {31'd0, busy_o}, 32'd0);
        waitrequest_i = 1'b0;
        readdata_i    = 32'h12345678;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'd0);
        chk("ar_addr2", address_o, 32'h0000_0104);
        @(negedge clk);
        chk("ar_done",  {31'd0, done_o}, 32'd1);
        chk("ar_rdata", rdata_o, 32'h12345678);
        @(negedge clk);

        // Signed half load from upper lanes
        readdata_i = 32'h80015555;
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0106, 32'd0);
        chk("sh_be",    {28'd0, byteenable_o}, 32'hC);
        @(negedge clk);
        chk("sh_rdata", rdata_o, 32'hFFFF8001);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter MAX_WAIT, default 255: waitrequest cycles before timeout; 0 disables timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 req_i  input  1  core access request, sampled only in IDLE.
REQ-005 we_i  input  1  1 = store, 0 = load.
REQ-006 size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 sign_i  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data, right-aligned.
REQ-010 busy_o  output  1  high whenever state != IDLE.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  one-cycle error pulse, coincident with done_o.
REQ-013 rdata_o  output  32  extended load result.
REQ-014 address_o  output  32  Avalon word address.
REQ-015 read_o / write_o  output  1 each  Avalon strobes.
REQ-016 waitrequest_i  input  1  Avalon stall.
REQ-017 writedata_o  output  32  lane-aligned store data.
REQ-018 byteenable_o  output  4  Avalon lane enables.
REQ-019 readdata_i  input  32  Avalon read data.

Function
REQ-020 FSM SHALL have states IDLE, READ, WRITE, RESP; all Avalon outputs registered.
REQ-021 IDLE & req_i & legal access: latch addr/size/sign/wdata; next state READ (we_i=0) or WRITE (we_i=1).
REQ-022 Illegal access (size 11; half with addr[0]=1; word with addr[1:0]!=00): no bus strobe; next state RESP with err_o=1.
REQ-023 read_o=1 only in READ, write_o=1 only in WRITE; address_o={addr[31:2],2'b00}, byteenable_o, writedata_o held stable until completion.
REQ-024 READ/WRITE completes at an edge where waitrequest_i=0; next state RESP; read/write deassert same edge.
REQ-025 Lanes little-endian: lane k = bits [8k+7:8k] = byte offset k.
REQ-026 byteenable_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-027 writedata_o: byte = wdata_i[7:0] in lane addr[1:0]; half = wdata_i[15:0] in lanes addr[1:0]..+1; word = wdata_i; unused lanes 0.
REQ-028 Load: byte/half extracted from addressed lane(s), extended per sign_i; word passes unchanged; captured into rdata_o at completing edge.
REQ-029 Store SHALL leave rdata_o unchanged; rdata_o holds until next load completion or error.
REQ-030 Wait counter clears on entering READ/WRITE, increments each cycle waitrequest_i=1.
REQ-031 MAX_WAIT!=0 and counter reaches MAX_WAIT: drop strobe, go RESP, err_o=1, rdata_o=0.
REQ-032 RESP lasts exactly one cycle: done_o=1 (err_o per REQ-022/031); next state IDLE.
REQ-033 Minimum latency: req accepted edge 1, strobe cycle 1, done_o cycle 2, new req accepted cycle 3.
REQ-034 req_i while busy_o=1 SHALL be ignored, not queued.

Reset
REQ-035 reset_i low: immediately (asynchronously) state IDLE; busy_o, done_o, err_o, read_o, write_o, byteenable_o, address_o, writedata_o, rdata_o, counter all 0.
REQ-036 Reset mid-transaction aborts it: strobes drop at once, no done_o after release.
REQ-037 After reset_i rises, first req_i accepted on first rising edge with req_i=1.

Verification
REQ-038 Word load addr 0x100, waitrequest 0, readdata 0xDEADBEEF -> address_o 0x100, byteenable 1111, done_o cycle 2, rdata_o 0xDEADBEEF.
REQ-039 Signed byte load addr 0x103, readdata 0x80112233 -> byteenable 1000, rdata_o 0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Half store addr 0x202, wdata 0x0000ABCD, waitrequest high 3 cycles -> write_o held 4 cycles, byteenable 1100, writedata 0xABCD0000, single done_o.
REQ-041 Word load addr 0x101 -> no read_o, done_o=err_o=1 cycle 1 after accept, rdata_o 0.
REQ-042 MAX_WAIT=4, waitrequest stuck high -> read_o drops after 4 cycles, done_o=err_o=1, rdata_o 0.
REQ-043 reset_i low during READ with waitrequest high -> read_o 0 immediately, no done_o; new load after release completes normally.
